// File: rtl/add16u_err_monitor.sv
// Error-characterisation monitor for unsigned approximate adders: accumulates
// count, error count, sum/max of |exact - approx| over 2**N_LOG2 samples.
// Optional feature: define ERRMON_MSE_EN to add the sum-of-squared-error port.
module add16u_err_monitor #(
  parameter int W      = 16,
  parameter int N_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [W:0]            o_approx,
  output logic                  busy,
  output logic                  done,
  output logic [N_LOG2:0]       sample_cnt,
  output logic [N_LOG2:0]       err_cnt,
  output logic [W+N_LOG2:0]     sum_abs_err,
  output logic [W:0]            max_err
`ifdef ERRMON_MSE_EN
  ,
  output logic [2*(W+1)+N_LOG2-1:0] sq_err_sum
`endif
);

  localparam int ACC_W = W + 1 + N_LOG2;
  localparam logic [N_LOG2:0] CNT_ONE  = (N_LOG2+1)'(1);
  localparam logic [N_LOG2:0] LAST_ACC = (N_LOG2+1)'((1 << N_LOG2) - 1);
  localparam logic [W:0]      E_ONE    = (W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic [N_LOG2:0]     r_acc_cnt;

  logic                r_s1_valid;
  logic [W-1:0]        r_s1_a;
  logic [W-1:0]        r_s1_b;
  logic [W:0]          r_s1_o;

  logic                r_s2_valid;
  logic [W:0]          r_s2_e;
  logic                r_s2_ne;

  logic [N_LOG2:0]     r_sample_cnt;
  logic [N_LOG2:0]     r_err_cnt;
  logic [ACC_W-1:0]    r_sum_abs_err;
  logic [W:0]          r_max_err;

  logic                w_accept;
  logic                w_start_go;
  logic                w_pipe_empty;
  logic [W:0]          w_exact;
  logic [W+1:0]        w_diff;
  logic [W:0]          w_e;

  assign w_accept     = in_valid & r_in_ready;
  assign w_start_go   = (r_state == ST_IDLE) & start;
  assign w_pipe_empty = ~r_s1_valid & ~r_s2_valid;

  // Control FSM; in_ready/busy/done are registered so none of them depends
  // combinationally on in_valid or start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_acc_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_acc_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_ONE;
            if (r_acc_cnt == LAST_ACC) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_o     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a <= a;
        r_s1_b <= b;
        r_s1_o <= o_approx;
      end
    end
  end

  // |exact - approx| always fits W+1 bits: the negative branch is a plain
  // two's-complement negate of the low bits.
  assign w_exact = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff  = {1'b0, w_exact} - {1'b0, r_s1_o};
  assign w_e     = w_diff[W+1] ? (~w_diff[W:0] + E_ONE) : w_diff[W:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_e     <= '0;
      r_s2_ne    <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_e  <= w_e;
        r_s2_ne <= |w_e;
      end
    end
  end

  // Result registers clear only on an accepted start; the pipeline is always
  // empty in IDLE so the clear and an update never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt  <= '0;
      r_err_cnt     <= '0;
      r_sum_abs_err <= '0;
      r_max_err     <= '0;
    end else if (w_start_go) begin
      r_sample_cnt  <= '0;
      r_err_cnt     <= '0;
      r_sum_abs_err <= '0;
      r_max_err     <= '0;
    end else if (r_s2_valid) begin
      r_sample_cnt  <= r_sample_cnt + CNT_ONE;
      r_err_cnt     <= r_err_cnt + {{N_LOG2{1'b0}}, r_s2_ne};
      r_sum_abs_err <= r_sum_abs_err + {{N_LOG2{1'b0}}, r_s2_e};
      if (r_s2_e > r_max_err) begin
        r_max_err <= r_s2_e;
      end
    end
  end

`ifdef ERRMON_MSE_EN
  localparam int SQ_W  = 2 * (W + 1);
  localparam int SQS_W = SQ_W + N_LOG2;

  logic [SQ_W-1:0]  w_sq;
  logic [SQ_W-1:0]  r_s2_sq;
  logic [SQS_W-1:0] r_sq_err_sum;

  assign w_sq = SQ_W'(w_e) * SQ_W'(w_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_sq      <= '0;
      r_sq_err_sum <= '0;
    end else begin
      if (r_s1_valid) begin
        r_s2_sq <= w_sq;
      end
      if (w_start_go) begin
        r_sq_err_sum <= '0;
      end else if (r_s2_valid) begin
        r_sq_err_sum <= r_sq_err_sum + {{N_LOG2{1'b0}}, r_s2_sq};
      end
    end
  end

  assign sq_err_sum = r_sq_err_sum;
`endif

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sample_cnt  = r_sample_cnt;
  assign err_cnt     = r_err_cnt;
  assign sum_abs_err = r_sum_abs_err;
  assign max_err     = r_max_err;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Randomized bench for add16u_err_monitor (W=16, N_LOG2=2): window results are
// compared against totals computed from the list of accepted samples.
module tb_add16u_err_monitor;

  localparam int W      = 16;
  localparam int N_LOG2 = 2;
  localparam int NS     = 1 << N_LOG2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         a = '0;
  logic [W-1:0]         b = '0;
  logic [W:0]           o_approx = '0;
  logic                 busy;
  logic                 done;
  logic [N_LOG2:0]      sample_cnt;
  logic [N_LOG2:0]      err_cnt;
  logic [W+N_LOG2:0]    sum_abs_err;
  logic [W:0]           max_err;
`ifdef ERRMON_MSE_EN
  logic [2*(W+1)+N_LOG2-1:0] sq_err_sum;
`endif

  add16u_err_monitor #(
    .W      (W),
    .N_LOG2 (N_LOG2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .o_approx    (o_approx),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .max_err     (max_err)
`ifdef ERRMON_MSE_EN
    ,
    .sq_err_sum  (sq_err_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sa;
    longint sb;
    longint so;
  } smp_t;

  smp_t acc_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Stimulus patterns: 0 exact adder, 1 fixed 0xFF+1 vs 0, 2 wrap then
  // overestimate, 3 random mix of exact/perturbed/garbage outputs.
  function automatic void gen(input int pat, input int idx,
                              output logic [W-1:0] ga, output logic [W-1:0] gb,
                              output logic [W:0] go);
    logic [W:0] ex;
    ga = W'($urandom);
    gb = W'($urandom);
    ex = {1'b0, ga} + {1'b0, gb};
    go = ex;
    case (pat)
      0: go = ex;
      1: begin ga = 16'h00FF; gb = 16'h0001; go = '0; end
      2: begin
        if (idx == 0) begin ga = 16'hFFFF; gb = 16'hFFFF; go = '0; end
        else begin ga = '0; gb = '0; go = 17'd5; end
      end
      default: begin
        case ($urandom_range(0, 2))
          0: go = ex;
          1: go = ex ^ (W+1)'($urandom_range(0, 255));
          default: go = (W+1)'($urandom);
        endcase
      end
    endcase
  endfunction

  task automatic model(output longint n, output longint errs, output longint sum,
                       output longint mx, output longint sq);
    n = 0; errs = 0; sum = 0; mx = 0; sq = 0;
    foreach (acc_q[i]) begin
      longint ex;
      longint e;
      ex = acc_q[i].sa + acc_q[i].sb;
      e  = (ex >= acc_q[i].so) ? ex - acc_q[i].so : acc_q[i].so - ex;
      n++;
      if (e != 0) errs++;
      sum += e;
      if (e > mx) mx = e;
      sq += e * e;
    end
  endtask

  task automatic open_window();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("open_busy", busy, 1);
    check_eq("open_ready", in_ready, 1);
    check_eq("open_cnt_clr", sample_cnt, 0);
    check_eq("open_max_clr", max_err, 0);
  endtask

  // Runs one window from the current negedge (state RUN) to the done pulse.
  task automatic run_window(input int win_id, input int pat, input int valid_pct,
                            input int hold_valid, input bit start_in_run,
                            input bit start_on_done);
    int acc = 0;
    int cyc = 0;
    bit seen = 0;
    longint n, errs, sum, mx, sq;
    logic [W-1:0] ga, gb;
    logic [W:0] go;
    acc_q.delete();
    while (!seen && cyc < 80) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        check_eq("ready", in_ready, (acc < NS) ? 1 : 0);
        check_eq("busy_run", busy, 1);
        start = start_in_run && (cyc == 1);
        gen(pat, acc, ga, gb, go);
        a = ga; b = gb; o_approx = go;
        in_valid = (cyc < hold_valid) || ($urandom_range(0, 99) < valid_pct);
        if (in_valid && acc < NS) begin
          acc_q.push_back('{sa: longint'(ga), sb: longint'(gb), so: longint'(go)});
          acc++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
    end
    model(n, errs, sum, mx, sq);
    check_eq("sample_cnt", sample_cnt, n);
    check_eq("err_cnt", err_cnt, errs);
    check_eq("sum_abs_err", sum_abs_err, sum);
    check_eq("max_err", max_err, mx);
`ifdef ERRMON_MSE_EN
    check_eq("sq_err_sum", sq_err_sum, sq);
`endif
    check_eq("busy_done", busy, 0);
    check_eq("ready_done", in_ready, 0);
    $display("window %0d: pat=%0d cycles=%0d samples=%0d err=%0d sum=%0d max=%0d",
             win_id, pat, cyc, n, errs, sum, mx);
    if (start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      check_eq("done_pulse_len", done, 0);
      check_eq("busy_after_done_start", busy, 0);
      check_eq("held_cnt", sample_cnt, n);
      check_eq("held_sum", sum_abs_err, sum);
      @(negedge clk);
      start = 1'b0;
      check_eq("restart_busy", busy, 1);
      check_eq("restart_ready", in_ready, 1);
      check_eq("restart_cnt_clr", sample_cnt, 0);
      check_eq("restart_sum_clr", sum_abs_err, 0);
    end else begin
      @(negedge clk);
      check_eq("done_pulse_len", done, 0);
      check_eq("held_cnt", sample_cnt, n);
      check_eq("held_max", max_err, mx);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_cnt"}, sample_cnt, 0);
    check_eq({tag, "_err"}, err_cnt, 0);
    check_eq({tag, "_sum"}, sum_abs_err, 0);
    check_eq({tag, "_max"}, max_err, 0);
`ifdef ERRMON_MSE_EN
    check_eq({tag, "_sq"}, sq_err_sum, 0);
`endif
  endtask

  initial begin
    logic [W-1:0] ga, gb;
    logic [W:0] go;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    open_window();
    run_window(1, 0, 70, 0, 1'b0, 1'b0);
    open_window();
    run_window(2, 1, 0, NS, 1'b0, 1'b0);
    open_window();
    run_window(3, 2, 0, NS, 1'b0, 1'b0);
    open_window();
    run_window(4, 3, 50, 10, 1'b0, 1'b0);
    open_window();
    run_window(5, 3, 60, 0, 1'b1, 1'b1);
    run_window(6, 0, 60, 0, 1'b0, 1'b0);

    // Abort a window once results are partially accumulated.
    open_window();
    for (int i = 0; i < 3; i++) begin
      gen(1, i, ga, gb, go);
      a = ga; b = gb; o_approx = go;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    open_window();
    run_window(7, 1, 80, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      open_window();
      run_window(8 + i, 3, 60, 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
